// File: rtl/instruction_fetch_stage.sv
// Purpose: MIPS IF stage. Holds the PC, fetches over a req/ready handshake, drives IF/ID.
// Latency: a completed fetch reaches IF/ID on the same edge (1 edge from request).
// Backpressure: a stall captures the returned word in a hold buffer and drops req until accepted.
//
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   pc_enable, IF_enable            hazard-unit permissions for PC update / IF/ID load
//   branch_taken, branch_target     redirect request and target (bits [1:0] ignored)
//   imem_req, imem_addr             fetch request and word-aligned fetch address
//   imem_ready, imem_rdata          memory handshake and returned instruction word
//   IF_ID_instruction/pc_plus4/valid  IF/ID pipeline register
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_enable,
  input  logic        IF_enable,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instruction,
  output logic [31:0] IF_ID_pc_plus4,
  output logic        IF_ID_valid
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] hold_buf;
  logic        done;
  logic        accept;

  assign pc_plus4  = pc + 32'd4;  // wraps modulo 2^32
  assign imem_addr = {pc[31:2], 2'b00};
  assign done      = imem_req && imem_ready;
  assign accept    = pc_enable && IF_enable;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a redirect always returns to FETCH
  always_comb begin
    state_next = state;
    if (branch_taken) begin
      state_next = FETCH;
    end else begin
      case (state)
        FETCH:   if (done && !accept) state_next = HELD;
        HELD:    if (accept)          state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end
  end

  // Output logic; request is gated by reset so nothing is issued while it is held high
  always_comb begin
    imem_req = (state == FETCH) && !reset;
  end

  // PC, hold buffer and IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc                <= RESET_PC;
      hold_buf          <= 32'd0;
      IF_ID_instruction <= NOP_INSTR;
      IF_ID_pc_plus4    <= 32'd0;
      IF_ID_valid       <= 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over stalls and discards any word returned this cycle
      pc                <= {branch_target[31:2], 2'b00};
      hold_buf          <= 32'd0;
      IF_ID_instruction <= NOP_INSTR;
      IF_ID_valid       <= 1'b0;
    end else if (state == FETCH && done && accept) begin
      pc                <= pc_plus4;
      IF_ID_instruction <= imem_rdata;
      IF_ID_pc_plus4    <= pc_plus4;
      IF_ID_valid       <= 1'b1;
    end else if (state == HELD && accept) begin
      pc                <= pc_plus4;
      IF_ID_instruction <= hold_buf;
      IF_ID_pc_plus4    <= pc_plus4;
      IF_ID_valid       <= 1'b1;
    end else begin
      // Word returned while stalled is parked so it is never refetched or lost
      if (state == FETCH && done) begin
        hold_buf <= imem_rdata;
      end
      // No new word for decode: bubble if IF/ID may load, otherwise hold
      if (IF_enable) begin
        IF_ID_instruction <= NOP_INSTR;
        IF_ID_valid       <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: holds the PC, fetches from instruction memory over a req/ready handshake, and drives the IF/ID pipeline register.
- Consumes pc_enable / IF_enable from hazard detection (load-use stall) and branch_taken / branch_target from the branch-resolution logic.
- Produces IF_ID_instruction, which feeds decode and hazard detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted for bubbles and flushes

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
pc_enable  input  1  1 = PC may update (from hazard detection)
IF_enable  input  1  1 = IF/ID register may load (from hazard detection)
branch_taken  input  1  redirect request; flushes IF/ID
branch_target  input  32  redirect PC; bits [1:0] ignored
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (current PC, word aligned)
imem_ready  input  1  memory accepts the request and returns data this cycle
imem_rdata  input  32  instruction word; valid when imem_req && imem_ready
IF_ID_instruction  output  32  IF/ID instruction register
IF_ID_pc_plus4  output  32  IF/ID PC+4 register
IF_ID_valid  output  1  1 = IF/ID holds a real instruction

Behaviour:
- Reset (async, any time) sets:
  - pc = RESET_PC; state = FETCH; hold buffer cleared.
  - IF_ID_instruction = NOP_INSTR; IF_ID_pc_plus4 = 0; IF_ID_valid = 0.
  - imem_req = 0 while reset is high. Any in-flight fetch is dropped.
- Definitions:
  - imem_addr = {pc[31:2], 2'b00}.
  - done = imem_req && imem_ready.
  - accept = pc_enable && IF_enable.
  - Requests are not sticky: addr and req may change on any cycle, and memory acts only on done.
- State FETCH: imem_req = 1.
  - done && accept: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay in FETCH. Fetch-to-IF/ID latency is 1 edge.
  - done && !accept: hold_buf <= imem_rdata; pc unchanged; go to HELD. IF/ID holds if IF_enable=0, or loads a bubble if IF_enable=1.
  - !done: pc unchanged. IF/ID loads a bubble (NOP_INSTR, valid=0, pc_plus4 unchanged) if IF_enable=1, and holds if IF_enable=0.
- State HELD: imem_req = 0.
  - accept: IF/ID <= {hold_buf, pc+4, valid=1}; pc <= pc+4; go to FETCH.
  - !accept: as in FETCH with !done (hold or bubble). No refetch.
- Redirect (branch_taken=1) has highest priority, overriding stall, done and HELD:
  - pc <= {branch_target[31:2], 2'b00}.
  - IF/ID <= {NOP_INSTR, pc_plus4 unchanged, valid=0}, regardless of IF_enable.
  - hold_buf discarded; state <= FETCH.
  - Any data returned with done in the same cycle is discarded.
- Arithmetic: pc+4 is 32-bit modulo, so 0xFFFF_FFFC + 4 = 0.
- Each fetched word is delivered to IF/ID exactly once or discarded by redirect; never duplicated or skipped.
- Target size: ~150-250 RTL lines (2-state FSM, pc, hold buffer, IF/ID register).

Test Plan:
- Reset, ready=1, mem[0]=0x20080005, mem[4]=0x20090007:
  - after edge 1: IF_ID_instruction=0x20080005, pc_plus4=4, valid=1.
  - after edge 2: 0x20090007, pc_plus4=8.
  - imem_addr sequence 0, 4, 8.
- imem_ready low for 2 cycles at addr 0x8 -> 2 bubbles (valid=0, NOP); imem_addr stays 0x8; the word at 0x8 enters IF/ID on the first ready cycle.
- Load-use stall: pc_enable=IF_enable=0 for 2 cycles while fetch of 0xC completes ->
  - IF/ID held; imem_req=0 for the following cycle.
  - word from 0xC loads on the first enable cycle; next imem_addr=0x10; no duplicate or lost word.
- branch_taken=1, target=0x43, while in HELD with IF_enable=0 ->
  - IF/ID = NOP, valid=0; next imem_addr=0x40; held word never appears.
- pc=0xFFFF_FFFC, fetch 0x1234_5678 -> IF_ID_pc_plus4=0, next imem_addr=0.
- Assert reset asynchronously mid-cycle in HELD ->
  - outputs immediately NOP, valid=0, imem_req=0.
  - after release, first imem_addr=RESET_PC.
